// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - state encodings, enable bundle and default widths for the stall controller
package pipeline_stall_controller_pkg;

  localparam int DEFAULT_STALL_CNT_W = 16;
  localparam int DEFAULT_MEM_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_HALT       = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam stage_en_t EN_ALL    = 5'b11111;
  localparam stage_en_t EN_NONE   = 5'b00000;
  // Front end held while ID/EX loads a bubble and the back end drains.
  localparam stage_en_t EN_BUBBLE = 5'b00111;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - saturating up-counter with sync reset and sync clear
module pipeline_stall_controller_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - prioritised stall/flush sequencer driving PC and pipeline-register enables
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int STALL_CNT_W = DEFAULT_STALL_CNT_W,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_use_hazard,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_enable,
  output logic                   IF_ID_enable,
  output logic                   ID_EX_enable,
  output logic                   EX_MEM_enable,
  output logic                   MEM_WB_enable,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [1:0]             ctrl_state
);

  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic             mem_timeout_q, mem_timeout_d;
  stage_en_t        en;
  logic             if_id_flush_c, id_ex_flush_c;
  logic             eval_run, load_use_ok;
  logic             tmo_clear, tmo_inc;
  logic [TMO_W-1:0] tmo_count;

  always_comb begin
    en            = EN_ALL;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    state_d       = state_q;
    tmo_clear     = 1'b0;
    tmo_inc       = 1'b0;
    eval_run      = 1'b0;
    load_use_ok   = 1'b0;

    case (state_q)
      ST_RUN: begin
        eval_run    = 1'b1;
        load_use_ok = 1'b1;
      end
      ST_LOAD_STALL: begin
        eval_run = 1'b1;
      end
      ST_MEM_WAIT: begin
        // Frozen cycles ignore branch_taken; EX still holds the branch at release.
        if (mem_ready) begin
          eval_run    = 1'b1;
          load_use_ok = 1'b1;
        end else begin
          en      = EN_NONE;
          tmo_inc = 1'b1;
          if (tmo_count == TMO_LAST) begin
            state_d = ST_HALT;
          end
        end
      end
      default: begin
        en = EN_NONE;
      end
    endcase

    if (eval_run) begin
      if (mem_req && !mem_ready) begin
        en        = EN_NONE;
        state_d   = ST_MEM_WAIT;
        tmo_clear = 1'b1;
      end else if (branch_taken) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        state_d       = ST_RUN;
      end else if (load_use_hazard && load_use_ok) begin
        en            = EN_BUBBLE;
        id_ex_flush_c = 1'b1;
        state_d       = ST_LOAD_STALL;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (reset) begin
      en            = EN_NONE;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
    end

    mem_timeout_d = mem_timeout_q | (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  pipeline_stall_controller_sat_counter #(
    .WIDTH(TMO_W)
  ) u_tmo_counter (
    .clk   (clk),
    .reset (reset),
    .clear (tmo_clear),
    .inc   (tmo_inc),
    .count (tmo_count)
  );

  pipeline_stall_controller_sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (~en.pc),
    .count (stall_count)
  );

  assign pc_enable     = en.pc;
  assign IF_ID_enable  = en.if_id;
  assign ID_EX_enable  = en.id_ex;
  assign EX_MEM_enable = en.ex_mem;
  assign MEM_WB_enable = en.mem_wb;
  assign IF_ID_flush   = if_id_flush_c;
  assign ID_EX_flush   = id_ex_flush_c;
  assign mem_timeout   = mem_timeout_q;
  assign ctrl_state    = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_use_hazard;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable;
  logic       IF_ID_flush, ID_EX_flush;
  logic       mem_timeout;
  logic [2:0] stall_count;
  logic [1:0] ctrl_state;
  logic [4:0] en_v;
  logic [1:0] fl_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .STALL_CNT_W(3),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_enable       (pc_enable),
    .IF_ID_enable    (IF_ID_enable),
    .ID_EX_enable    (ID_EX_enable),
    .EX_MEM_enable   (EX_MEM_enable),
    .MEM_WB_enable   (MEM_WB_enable),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .ctrl_state      (ctrl_state)
  );

  assign en_v = {pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable};
  assign fl_v = {IF_ID_flush, ID_EX_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic br, input logic req, input logic rdy);
    load_use_hazard = lu;
    branch_taken    = br;
    mem_req         = req;
    mem_ready       = rdy;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("reset_enables", en_v, 5'b00000);
    chk("reset_flushes", fl_v, 2'b00);
    tick();
    chk("reset_state", ctrl_state, 2'd0);
    chk("reset_timeout", mem_timeout, 1'b0);
    chk("reset_count", stall_count, 3'd0);
    reset = 1'b0;

    // Load-use held two cycles: one bubble only
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("lu_c0_enables", en_v, 5'b00111);
    chk("lu_c0_flushes", fl_v, 2'b01);
    tick();
    chk("lu_c1_state", ctrl_state, 2'd1);
    settle();
    chk("lu_c1_enables", en_v, 5'b11111);
    chk("lu_c1_flushes", fl_v, 2'b00);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_back_state", ctrl_state, 2'd0);
    chk("lu_count", stall_count, 3'd1);

    // Branch beats coincident load-use
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("br_lu_enables", en_v, 5'b11111);
    chk("br_lu_flushes", fl_v, 2'b11);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_lu_state", ctrl_state, 2'd0);
    chk("br_lu_count", stall_count, 3'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_count", stall_count, 3'd0);

    // Memory wait: three frozen cycles then release
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("mw_c0_enables", en_v, 5'b00000);
    tick();
    chk("mw_c1_state", ctrl_state, 2'd2);
    settle();
    chk("mw_c1_enables", en_v, 5'b00000);
    tick();
    settle();
    chk("mw_c2_enables", en_v, 5'b00000);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("mw_rel_enables", en_v, 5'b11111);
    chk("mw_rel_flushes", fl_v, 2'b00);
    chk("mw_count", stall_count, 3'd3);
    tick();
    chk("mw_rel_state", ctrl_state, 2'd0);

    // Single-cycle memory access causes no stall
    set_in(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("mem1_enables", en_v, 5'b11111);
    tick();
    chk("mem1_state", ctrl_state, 2'd0);
    chk("mem1_count", stall_count, 3'd3);

    // Branch held through a two-cycle wait acts only at release
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("brw_c0_enables", en_v, 5'b00000);
    chk("brw_c0_flushes", fl_v, 2'b00);
    tick();
    settle();
    chk("brw_c1_flushes", fl_v, 2'b00);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("brw_rel_enables", en_v, 5'b11111);
    chk("brw_rel_flushes", fl_v, 2'b11);
    tick();
    chk("brw_state", ctrl_state, 2'd0);
    chk("brw_count", stall_count, 3'd5);

    // Load-use at release inserts a bubble
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("luw_rel_enables", en_v, 5'b00111);
    chk("luw_rel_flushes", fl_v, 2'b01);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("luw_state", ctrl_state, 2'd1);
    chk("luw_count", stall_count, 3'd7);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Timeout to HALT, then saturation of the stall counter
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("tmo_pre_state", ctrl_state, 2'd2);
    chk("tmo_pre_flag", mem_timeout, 1'b0);
    chk("tmo_pre_count", stall_count, 3'd4);
    tick();
    chk("tmo_halt_state", ctrl_state, 2'd3);
    chk("tmo_halt_flag", mem_timeout, 1'b1);
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("halt_enables", en_v, 5'b00000);
    chk("halt_flushes", fl_v, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_count", stall_count, 3'd7);
    chk("sat_state", ctrl_state, 2'd3);

    reset = 1'b1;
    settle();
    chk("rst_halt_enables", en_v, 5'b00000);
    tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_halt_state", ctrl_state, 2'd0);
    chk("rst_halt_flag", mem_timeout, 1'b0);
    chk("rst_halt_count", stall_count, 3'd0);
    settle();
    chk("post_rst_enables", en_v, 5'b11111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
